// File: rtl/icache_pkg.sv
// Shared state encoding and address-geometry helpers for the direct-mapped
// instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    FILL_DONE
  } icache_state_t;

  localparam logic [31:0] RESET_INSTR_DEF = 32'h0000_0000;

  function automatic int offset_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  // The byte offset pc[1:0] is never part of the lookup.
  function automatic int tag_w(input int lines, input int words_per_line);
    return 32 - 2 - $clog2(lines) - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Line-refill bus between the instruction cache (master) and the slow
// instruction memory (slave).
interface icache_dm_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ready, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ready, output mem_rdata);
endinterface

// File: rtl/icache_refill_fsm.sv
// Miss handling for icache_dm: owns the miss register, word counter, refill
// bus request and deferred flush; strobes writes into the cache arrays.
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int  LINES          = 16,
  parameter int  WORDS_PER_LINE = 4,
  localparam int OFFSET_W       = offset_w(WORDS_PER_LINE),
  localparam int INDEX_W        = index_w(LINES),
  localparam int TAG_W          = tag_w(LINES, WORDS_PER_LINE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                hit,
  input  logic [TAG_W-1:0]    pc_tag,
  input  logic [INDEX_W-1:0]  pc_index,
  icache_dm_if.master         mem,
  output logic                busy,
  output logic                word_we,
  output logic                line_we,
  output logic                valid_clr,
  output logic [TAG_W-1:0]    miss_tag,
  output logic [INDEX_W-1:0]  miss_index,
  output logic [OFFSET_W-1:0] word_sel
);
  // state     | meaning
  // IDLE      | lookup active, a miss latches {tag,index} and starts refill
  // REFILL    | requesting words 0..WORDS_PER_LINE-1 of the missed line
  // FILL_DONE | line written, one bubble before the re-lookup hits

  icache_state_t       state_q, state_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0]  miss_index_q, miss_index_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic                pend_q, pend_d;
  logic                accept, last;

  assign accept  = mem_req_q & mem.mem_ready;
  assign last    = (cnt_q == OFFSET_W'(WORDS_PER_LINE - 1));
  assign cnt_inc = cnt_q + OFFSET_W'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    pend_d       = pend_q;
    word_we      = 1'b0;
    line_we      = 1'b0;
    valid_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        valid_clr = flush;
        if (!hit) begin
          state_d      = REFILL;
          miss_tag_d   = pc_tag;
          miss_index_d = pc_index;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          mem_addr_d   = {pc_tag, pc_index, {OFFSET_W{1'b0}}, 2'b00};
        end
      end
      REFILL: begin
        if (flush) pend_d = 1'b1;
        if (accept) begin
          word_we    = 1'b1;
          cnt_d      = cnt_inc;
          mem_addr_d = {miss_tag_q, miss_index_q, cnt_inc, 2'b00};
          if (last) begin
            state_d   = FILL_DONE;
            mem_req_d = 1'b0;
            pend_d    = 1'b0;
            // A flush seen at any point of the refill wins over validation.
            if (pend_q || flush) valid_clr = 1'b1;
            else                 line_we   = 1'b1;
          end
        end
      end
      FILL_DONE: begin
        state_d   = IDLE;
        valid_clr = flush;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      pend_q       <= pend_d;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign busy         = (state_q != IDLE);
  assign miss_tag     = miss_tag_q;
  assign miss_index   = miss_index_q;
  assign word_sel     = cnt_q;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with zero-latency hits.
// Optional hit/miss statistics ports are enabled by defining ICACHE_STATS_EN.
module icache_dm
  import icache_pkg::*;
#(
  parameter int          LINES          = 16,
  parameter int          WORDS_PER_LINE = 4,
  parameter logic [31:0] RESET_INSTR    = RESET_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        stall,
  icache_dm_if.master mem
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int OFFSET_W = offset_w(WORDS_PER_LINE);
  localparam int INDEX_W  = index_w(LINES);
  localparam int TAG_W    = tag_w(LINES, WORDS_PER_LINE);

  logic [OFFSET_W-1:0] pc_off, word_sel;
  logic [INDEX_W-1:0]  pc_index, miss_index;
  logic [TAG_W-1:0]    pc_tag, miss_tag;
  logic                pc_unused;
  logic                hit, busy, word_we, line_we, valid_clr;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [TAG_W-1:0] tag_d  [LINES];
  logic [31:0]      data_q [LINES][WORDS_PER_LINE];
  logic [31:0]      data_d [LINES][WORDS_PER_LINE];

  assign pc_off    = pc[2 +: OFFSET_W];
  assign pc_index  = pc[2 + OFFSET_W +: INDEX_W];
  assign pc_tag    = pc[31 -: TAG_W];
  assign pc_unused = ^pc[1:0];

  assign hit   = valid_q[pc_index] & (tag_q[pc_index] == pc_tag);
  assign stall = reset | busy | ~hit;
  assign instr = stall ? RESET_INSTR : data_q[pc_index][pc_off];

  icache_refill_fsm #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_refill (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .hit        (hit),
    .pc_tag     (pc_tag),
    .pc_index   (pc_index),
    .mem        (mem),
    .busy       (busy),
    .word_we    (word_we),
    .line_we    (line_we),
    .valid_clr  (valid_clr),
    .miss_tag   (miss_tag),
    .miss_index (miss_index),
    .word_sel   (word_sel)
  );

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (word_we) data_d[miss_index][word_sel] = mem.mem_rdata;
    if (valid_clr) begin
      valid_d = '0;
    end else if (line_we) begin
      valid_d[miss_index] = 1'b1;
      tag_d[miss_index]   = miss_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  // Only IDLE lookups count; refill stall cycles are invisible here.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (!busy && hit && hit_count_q != 32'hFFFF_FFFF)
      hit_count_d = hit_count_q + 32'd1;
    if (!busy && !hit && miss_count_q != 32'hFFFF_FFFF)
      miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm with a line-level reference model of the
// cache contents and refill transactions.
module tb_icache_dm;
  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        stall;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_dm_if mem_bus ();

  icache_dm #(
    .LINES          (16),
    .WORDS_PER_LINE (4),
    .RESET_INSTR    (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .flush      (flush),
    .instr      (instr),
    .stall      (stall),
    .mem        (mem_bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  assign mem_bus.mem_rdata = mem_word(mem_bus.mem_addr);

  // Memory: ready_gap idle cycles before each accepted word.
  int ready_gap = 0;
  int gap_cnt   = 0;
  always @(posedge clk) begin
    #1;
    if (reset || !mem_bus.mem_req) begin
      gap_cnt = 0;
      mem_bus.mem_ready = 1'b0;
    end else begin
      if (mem_bus.mem_ready) gap_cnt = 0;
      mem_bus.mem_ready = (gap_cnt >= ready_gap);
      gap_cnt++;
    end
  end

  // Reference model: which lines hold which tag, plus the refill in flight.
  bit          model_ok = 0;
  bit          m_valid [16];
  logic [23:0] m_tag   [16];
  bit          m_busy, m_filling, m_pend;
  logic [31:0] m_base;
  int          m_acc;
  logic [31:0] m_hits, m_misses;
  logic [31:0] acc_q [$];
  int          m_idx;
  bit          m_hit;

  always @(negedge clk) begin
    if (reset) begin
      chk("reset_stall", {31'd0, stall}, 32'd1);
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
      m_busy = 0; m_filling = 0; m_pend = 0;
      m_hits = 0; m_misses = 0;
      model_ok = 1;
    end else if (model_ok) begin
`ifdef ICACHE_STATS_EN
      chk("hit_count", hit_count, m_hits);
      chk("miss_count", miss_count, m_misses);
`endif
      m_idx = int'(pc[7:4]);
      m_hit = m_valid[m_idx] && (m_tag[m_idx] == pc[31:8]);
      if (!m_busy) begin
        chk("idle_stall", {31'd0, stall}, {31'd0, !m_hit});
        chk("idle_instr", instr, m_hit ? mem_word({pc[31:2], 2'b00}) : 32'h0);
        chk("idle_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
        if (m_hit) begin
          if (m_hits != 32'hFFFF_FFFF) m_hits++;
        end else if (m_misses != 32'hFFFF_FFFF) m_misses++;
        if (flush) for (int i = 0; i < 16; i++) m_valid[i] = 0;
        if (!m_hit) begin
          m_busy = 1; m_filling = 1; m_acc = 0;
          m_base = {pc[31:4], 4'h0};
        end
      end else if (m_filling) begin
        chk("refill_stall", {31'd0, stall}, 32'd1);
        chk("refill_instr", instr, 32'h0);
        chk("refill_mem_req", {31'd0, mem_bus.mem_req}, 32'd1);
        chk("refill_mem_addr", mem_bus.mem_addr, m_base + 32'(4 * m_acc));
        if (flush) m_pend = 1;
        if (mem_bus.mem_ready) begin
          acc_q.push_back(mem_bus.mem_addr);
          m_acc++;
          if (m_acc == 4) begin
            m_filling = 0;
            if (m_pend) for (int i = 0; i < 16; i++) m_valid[i] = 0;
            else begin
              m_valid[int'(m_base[7:4])] = 1;
              m_tag[int'(m_base[7:4])]   = m_base[31:8];
            end
            m_pend = 0;
          end
        end
      end else begin
        chk("done_stall", {31'd0, stall}, 32'd1);
        chk("done_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
        if (flush) for (int i = 0; i < 16; i++) m_valid[i] = 0;
        m_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold pc until the cache delivers; flush is pulsed in cycle flush_at.
  task automatic access(input logic [31:0] a, input int flush_at,
                        output int stalls, output logic [31:0] got);
    bit done = 0;
    pc = a;
    stalls = 0;
    got = 32'h0;
    for (int k = 0; k < 100 && !done; k++) begin
      flush = (k == flush_at);
      @(negedge clk);
      if (!stall) begin
        done = 1;
        got = instr;
      end else stalls++;
      tick();
    end
    flush = 1'b0;
    chk("access_done", {31'd0, done}, 32'd1);
  endtask

  task automatic chk_addrs(input string nm, input logic [31:0] base);
    chk({nm, "_count"}, acc_q.size(), 32'd4);
    for (int i = 0; i < acc_q.size() && i < 4; i++)
      chk(nm, acc_q[i], base + 32'(4 * i));
  endtask

  int          st;
  logic [31:0] got;

  initial begin
    reset = 1'b1; flush = 1'b0; pc = 32'h40;
    mem_bus.mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
    chk("reset_mem_addr", mem_bus.mem_addr, 32'd0);
    tick();
    reset = 1'b0;

    // Cold miss with memory always ready.
    acc_q.delete();
    access(32'h40, -1, st, got);
    chk("cold_stalls", st, 32'd6);
    chk("cold_instr", got, 32'hC09E_0040);
    chk_addrs("cold_addr", 32'h40);
    access(32'h4C, -1, st, got);
    chk("hit_4c_stalls", st, 32'd0);
    chk("hit_4c_instr", got, 32'hC092_004C);

    // Backpressure: three idle cycles before each word.
    ready_gap = 3;
    acc_q.delete();
    access(32'h100, -1, st, got);
    chk("bp_stalls", st, 32'd18);
    chk("bp_instr", got, 32'hC1DE_0100);
    chk_addrs("bp_addr", 32'h100);
    ready_gap = 0;

    // Conflict eviction on index 0.
    access(32'h0, -1, st, got);
    chk("evict_fill0_stalls", st, 32'd6);
    access(32'h100, -1, st, got);
    chk("evict_100_stalls", st, 32'd6);
    access(32'h0, -1, st, got);
    chk("evict_back0_stalls", st, 32'd6);
    chk("evict_back0_instr", got, 32'hC0DE_0000);

    // Flush in IDLE: same-cycle lookup still hits, next access misses.
    access(32'h0, 0, st, got);
    chk("flush_idle_hit_stalls", st, 32'd0);
    access(32'h0, -1, st, got);
    chk("flush_idle_after_stalls", st, 32'd6);

    // Flush mid-refill: line not validated, so a second refill follows.
    access(32'h200, 2, st, got);
    chk("flush_refill_stalls", st, 32'd12);
    chk("flush_refill_instr", got, 32'hC2DE_0200);
    access(32'h208, -1, st, got);
    chk("flush_refill_hit", st, 32'd0);

    // Reset after two accepted words of 0x300.
    acc_q.delete();
    pc = 32'h300;
    repeat (3) tick();
    chk("rst_mid_words", acc_q.size(), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    acc_q.delete();
    @(negedge clk);
    chk("rst_mid_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd1);
    tick();
    access(32'h300, -1, st, got);
    chk("rst_mid_stalls", st, 32'd5);
    chk_addrs("rst_mid_addr", 32'h300);

`ifdef ICACHE_STATS_EN
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    access(32'h500, -1, st, got);
    pc = 32'h504; tick();
    pc = 32'h508; tick();
    pc = 32'h50C; tick();
    pc = 32'h500; tick();
    flush = 1'b1;
    @(negedge clk);
    chk("stats_hits5", hit_count, 32'd5);
    chk("stats_miss1", miss_count, 32'd1);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("stats_flush_hits", hit_count, 32'd6);
    chk("stats_flush_miss", miss_count, 32'd1);
    tick();
    access(32'h500, -1, st, got);
    @(negedge clk);
    chk("stats_refill_hits", hit_count, 32'd7);
    chk("stats_refill_miss", miss_count, 32'd2);
`endif

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
